// File: rtl/writeback_scheduler_if.sv
// Bundle of decode reservation, write-back request and register-file write signals
// shared between the writeback scheduler and its neighbours.
interface writeback_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              resv_valid;
  logic [ADDR_W-1:0] resv_addr;
  logic              resv_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DEPTH-1:0]  busy_vec;
  logic              err_unreserved;

  modport master (
    output resv_valid, resv_addr, rs_addr, rt_addr,
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  resv_ready, rs_busy, rt_busy, alu_ready, mem_ready,
    input  rf_we, rf_addr, rf_data, busy_vec, err_unreserved
  );

  modport slave (
    input  resv_valid, resv_addr, rs_addr, rt_addr,
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output resv_ready, rs_busy, rt_busy, alu_ready, mem_ready,
    output rf_we, rf_addr, rf_data, busy_vec, err_unreserved
  );
endinterface

// File: rtl/writeback_scheduler.sv
// Round-robin ALU/MEM write-back arbiter driving the single register-file write
// port, plus the busy scoreboard decode uses for RAW/WAW stalls.
module writeback_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                  clock,
  input logic                  reset,
  writeback_scheduler_if.slave wb
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] LAST_ALU = 1'b0;
  localparam logic [0:0] LAST_MEM = 1'b1;

  logic [0:0]        last_q, last_d;
  logic              grant_alu_c, grant_mem_c, grant_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              err_q, err_d;
  logic              resv_fire_c;

  // Arbitration pointer: names the requester granted most recently
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= LAST_MEM;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d      = last_q;
    grant_alu_c = 1'b0;
    grant_mem_c = 1'b0;
    sel_addr_c  = wb.alu_addr;
    sel_data_c  = wb.alu_data;
    if (wb.alu_valid && (!wb.mem_valid || last_q == LAST_MEM)) begin
      grant_alu_c = 1'b1;
      last_d      = LAST_ALU;
    end else if (wb.mem_valid) begin
      grant_mem_c = 1'b1;
      last_d      = LAST_MEM;
      sel_addr_c  = wb.mem_addr;
      sel_data_c  = wb.mem_data;
    end
  end

  assign grant_c = grant_alu_c | grant_mem_c;

  // Scoreboard: commit clears, reservation sets; a same-index set wins
  always_comb begin
    resv_fire_c = wb.resv_valid && !busy_q[wb.resv_addr];
    busy_d      = busy_q;
    err_d       = err_q;
    if (rf_we_q) begin
      busy_d[rf_addr_q] = 1'b0;
      if (!busy_q[rf_addr_q]) err_d = 1'b1;
    end
    if (resv_fire_c) busy_d[wb.resv_addr] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rf_we_q <= grant_c;
      if (grant_c) begin
        rf_addr_q <= sel_addr_c;
        rf_data_q <= sel_data_c;
      end
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign wb.alu_ready      = grant_alu_c;
  assign wb.mem_ready      = grant_mem_c;
  assign wb.resv_ready     = !busy_q[wb.resv_addr];
  assign wb.rs_busy        = busy_q[wb.rs_addr];
  assign wb.rt_busy        = busy_q[wb.rt_addr];
  assign wb.rf_we          = rf_we_q;
  assign wb.rf_addr        = rf_addr_q;
  assign wb.rf_data        = rf_data_q;
  assign wb.busy_vec       = busy_q;
  assign wb.err_unreserved = err_q;
endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed and randomized bench for writeback_scheduler against a behavioural
// model of arbitration, the write pipeline and the busy scoreboard.
module tb_writeback_scheduler;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  writeback_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();
  writeback_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock),
    .reset(reset),
    .wb   (wb)
  );

  always #5 clock = ~clock;

  // Model state: what the registered outputs must show in the current cycle
  bit [31:0]   m_busy;
  bit          m_last_mem;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  int          m_gnt;  // 0 none, 1 ALU, 2 MEM granted in the last checked cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit av, input bit mv, input bit last_mem);
    if (av && mv) return last_mem ? 1 : 2;
    if (av) return 1;
    if (mv) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_last_mem = 1'b1; m_we = 1'b0;
    m_addr = '0; m_data = '0; m_err = 1'b0; m_gnt = 0;
  endtask

  initial begin : compare
    int g;
    bit acc;
    model_reset();
    forever begin
      @(negedge clock);
      if (reset) begin
        model_reset();
        check("rst_rf_we", 32'(wb.rf_we), 32'd0);
        check("rst_busy_vec", wb.busy_vec, 32'd0);
        check("rst_err", 32'(wb.err_unreserved), 32'd0);
      end else begin
        g = pick(wb.alu_valid, wb.mem_valid, m_last_mem);
        check("alu_ready", 32'(wb.alu_ready), 32'(g == 1));
        check("mem_ready", 32'(wb.mem_ready), 32'(g == 2));
        check("resv_ready", 32'(wb.resv_ready), 32'(!m_busy[wb.resv_addr]));
        check("rs_busy", 32'(wb.rs_busy), 32'(m_busy[wb.rs_addr]));
        check("rt_busy", 32'(wb.rt_busy), 32'(m_busy[wb.rt_addr]));
        check("rf_we", 32'(wb.rf_we), 32'(m_we));
        check("rf_addr", 32'(wb.rf_addr), 32'(m_addr));
        check("rf_data", wb.rf_data, m_data);
        check("busy_vec", wb.busy_vec, m_busy);
        check("err_unreserved", 32'(wb.err_unreserved), 32'(m_err));
        m_gnt = g;
        // Advance to the state the coming posedge must produce
        acc = wb.resv_valid && !m_busy[wb.resv_addr];
        if (m_we) begin
          if (!m_busy[m_addr]) m_err = 1'b1;
          m_busy[m_addr] = 1'b0;
        end
        if (acc) m_busy[wb.resv_addr] = 1'b1;
        m_we = (g != 0);
        if (g == 1) begin m_addr = wb.alu_addr; m_data = wb.alu_data; end
        if (g == 2) begin m_addr = wb.mem_addr; m_data = wb.mem_data; end
        if (g != 0) m_last_mem = (g == 2);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.mem_valid = 1'b0; wb.resv_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    bit ap, mp;
    logic [4:0] aa, ma;
    logic [31:0] ad, md;
    wb.resv_valid = 1'b0; wb.resv_addr = '0; wb.rs_addr = '0; wb.rt_addr = '0;
    wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_addr = '0; wb.mem_data = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Single ALU write to a reserved register
    wb.resv_valid = 1'b1; wb.resv_addr = 5'd5;
    cyc();
    wb.resv_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_addr = 5'd5; wb.alu_data = 32'hDEADBEEF;
    @(negedge clock);
    check("t1_alu_ready", 32'(wb.alu_ready), 32'd1);
    check("t1_busy5_set", 32'(wb.busy_vec[5]), 32'd1);
    cyc();
    wb.alu_valid = 1'b0;
    @(negedge clock);
    check("t1_rf_we", 32'(wb.rf_we), 32'd1);
    check("t1_rf_addr", 32'(wb.rf_addr), 32'd5);
    check("t1_rf_data", wb.rf_data, 32'hDEADBEEF);
    cyc();
    @(negedge clock);
    check("t1_busy5_clear", 32'(wb.busy_vec[5]), 32'd0);
    check("t1_rf_we_drop", 32'(wb.rf_we), 32'd0);
    check("t1_err", 32'(wb.err_unreserved), 32'd0);

    // Both requesters continuously valid: grants alternate, no gaps
    do_reset();
    wb.resv_valid = 1'b1; wb.resv_addr = 5'd3;
    cyc();
    wb.resv_addr = 5'd4;
    cyc();
    wb.alu_addr = 5'd3; wb.alu_data = 32'h3333;
    wb.mem_addr = 5'd4; wb.mem_data = 32'h4444;
    for (int k = 0; k < 5; k++) begin
      wb.alu_valid  = (k < 4);
      wb.mem_valid  = (k < 4);
      wb.resv_valid = (k == 2 || k == 3);
      wb.resv_addr  = (k == 2) ? 5'd3 : 5'd4;
      @(negedge clock);
      if (k < 4) begin
        check("t2_alu_ready", 32'(wb.alu_ready), 32'(k % 2 == 0));
        check("t2_mem_ready", 32'(wb.mem_ready), 32'(k % 2 == 1));
      end
      if (k >= 1) begin
        check("t2_rf_we", 32'(wb.rf_we), 32'd1);
        check("t2_rf_addr", 32'(wb.rf_addr), (k % 2 == 1) ? 32'd3 : 32'd4);
      end
      cyc();
    end
    @(negedge clock);
    check("t2_err", 32'(wb.err_unreserved), 32'd0);

    // Hazard tracking on 7, and no bypass for a reservation during the clear
    do_reset();
    wb.resv_valid = 1'b1; wb.resv_addr = 5'd7;
    cyc();
    wb.rs_addr = 5'd7;
    @(negedge clock);
    check("t3_rs_busy_a", 32'(wb.rs_busy), 32'd1);
    check("t3_resv_refused_a", 32'(wb.resv_ready), 32'd0);
    cyc();
    wb.mem_valid = 1'b1; wb.mem_addr = 5'd7; wb.mem_data = 32'h7777;
    @(negedge clock);
    check("t3_mem_ready", 32'(wb.mem_ready), 32'd1);
    cyc();
    wb.mem_valid = 1'b0;
    @(negedge clock);
    check("t3_rf_addr", 32'(wb.rf_addr), 32'd7);
    check("t3_rs_busy_b", 32'(wb.rs_busy), 32'd1);
    check("t3_resv_refused_b", 32'(wb.resv_ready), 32'd0);
    cyc();
    @(negedge clock);
    check("t3_rs_busy_clear", 32'(wb.rs_busy), 32'd0);
    check("t3_resv_accept", 32'(wb.resv_ready), 32'd1);
    cyc();
    wb.resv_valid = 1'b0;
    @(negedge clock);
    check("t3_busy_vec", wb.busy_vec, 32'h0000_0080);

    // Unreserved MEM write to 9: committed and flagged, sticky until reset
    do_reset();
    wb.mem_valid = 1'b1; wb.mem_addr = 5'd9; wb.mem_data = 32'h9999;
    @(negedge clock);
    check("t4_mem_ready", 32'(wb.mem_ready), 32'd1);
    cyc();
    wb.mem_valid = 1'b0;
    @(negedge clock);
    check("t4_rf_we", 32'(wb.rf_we), 32'd1);
    check("t4_rf_addr", 32'(wb.rf_addr), 32'd9);
    check("t4_err_not_yet", 32'(wb.err_unreserved), 32'd0);
    cyc();
    wb.resv_valid = 1'b1; wb.resv_addr = 5'd2;
    @(negedge clock);
    check("t4_err_set", 32'(wb.err_unreserved), 32'd1);
    cyc();
    wb.resv_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_addr = 5'd2; wb.alu_data = 32'h2222;
    cyc();
    wb.alu_valid = 1'b0;
    cyc(); cyc();
    @(negedge clock);
    check("t4_err_sticky", 32'(wb.err_unreserved), 32'd1);
    do_reset();
    @(negedge clock);
    check("t4_err_cleared", 32'(wb.err_unreserved), 32'd0);

    // Reset in the cycle after a grant drops the write; ALU wins the next tie
    wb.alu_valid = 1'b1; wb.alu_addr = 5'd1; wb.alu_data = 32'h1111;
    wb.mem_valid = 1'b1; wb.mem_addr = 5'd2; wb.mem_data = 32'h2222;
    cyc();
    reset = 1'b1;
    @(negedge clock);
    check("t5_rf_we_dropped", 32'(wb.rf_we), 32'd0);
    check("t5_busy_vec", wb.busy_vec, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t5_no_pulse", 32'(wb.rf_we), 32'd0);
    check("t5_alu_tie", 32'(wb.alu_ready), 32'd1);
    check("t5_mem_tie", 32'(wb.mem_ready), 32'd0);
    cyc();
    idle();
    cyc();

    // Randomized traffic with occasional resets
    ap = 1'b0; mp = 1'b0;
    aa = '0; ma = '0; ad = '0; md = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        ap = 1'b0; mp = 1'b0;
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
      end
      if (ap && m_gnt == 1) ap = 1'b0;
      if (mp && m_gnt == 2) mp = 1'b0;
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1'b1; aa = rnd_addr(); ad = $urandom;
      end
      if (!mp && $urandom_range(0, 2) != 0) begin
        mp = 1'b1; ma = rnd_addr(); md = $urandom;
      end
      wb.alu_valid = ap; wb.alu_addr = aa; wb.alu_data = ad;
      wb.mem_valid = mp; wb.mem_addr = ma; wb.mem_data = md;
      wb.resv_valid = 1'($urandom_range(0, 1));
      wb.resv_addr = rnd_addr();
      wb.rs_addr = rnd_addr();
      wb.rt_addr = rnd_addr();
      cyc();
    end
    idle();
    cyc(); cyc();
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_scheduler.md
# writeback_scheduler

Sequences the register file's single write port and tracks in-flight destination registers. It arbitrates write-back requests from the ALU and memory stages with round-robin fairness, then drives one registered write per cycle into the register file. It also keeps a 32-entry busy scoreboard that decode uses to stall RAW and WAW hazards. It sits between the execute/memory stages and the register file's write controls.

## Interface
- DATA_W, 32, write-back data width
- ADDR_W, 5, register index width; scoreboard depth is 2**ADDR_W
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- resv_valid  in  1  decode requests a destination reservation
- resv_addr  in  ADDR_W  destination register to reserve
- resv_ready  out  1  combinational; reservation accepted when resv_valid && resv_ready
- rs_addr, rt_addr  in  ADDR_W  source indices being decoded
- rs_busy, rt_busy  out  1  combinational; busy_vec[rs_addr] / busy_vec[rt_addr]
- alu_valid  in  1  ALU write-back request
- alu_addr, alu_data  in  ADDR_W, DATA_W  ALU destination and data
- alu_ready  out  1  ALU request granted this cycle
- mem_valid  in  1  memory write-back request
- mem_addr, mem_data  in  ADDR_W, DATA_W  memory destination and data
- mem_ready  out  1  memory request granted this cycle
- rf_we  out  1  registered register-file write enable
- rf_addr  out  ADDR_W  registered write index
- rf_data  out  DATA_W  registered write data
- busy_vec  out  2**ADDR_W  registered scoreboard; bit i set means a write to register i is pending
- err_unreserved  out  1  sticky; set when a write commits to a register whose busy bit is clear

## Operation
- Arbitration is round-robin with a 1-bit `last` pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not named by `last` is granted.
  - `last` updates to the granted requester.
- A grant is a transfer: `*_ready` is high only in the cycle it is granted. The requester holds valid, addr and data until it sees ready.
- The granted addr/data is registered into rf_addr/rf_data, and rf_we is high for exactly the next cycle. With no grant, rf_we=0 and rf_addr/rf_data hold their values.
- Scoreboard set: on an accepted reservation, busy_vec[resv_addr] is set at the next posedge.
- Scoreboard clear: in a cycle with rf_we=1, busy_vec[rf_addr] is cleared at the posedge ending that cycle.
- resv_ready = !busy_vec[resv_addr]. There is no bypass: a reservation to an index being cleared this cycle is refused and is accepted the following cycle.
- If a set and a clear hit the same index in one cycle (only possible via an unreserved write), the set wins.
- Register 0 is an ordinary register: it is reserved, tracked and written like any other.
- Commit to a non-busy index: the write is still performed, and err_unreserved is set and held until reset.
- rs_busy/rt_busy reflect only registered busy_vec. A reservation accepted this cycle is not visible until the next cycle.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, busy_vec=0, err_unreserved=0, `last`=MEM, so ALU wins the first tie.
- Reset mid-operation drops any granted-but-uncommitted write; no rf_we pulse follows reset deassertion.
- Request-to-write latency is 1 cycle: grant in cycle N, rf_we=1 in N+1.
- The register file writes on the negedge of cycle N+1. busy bit clear and data visibility both take effect at the N+2 posedge, so a stalled reader reads the new value in N+2.
- Throughput is one write per cycle. With both requesters continuously valid, grants alternate every cycle.
- Combinational outputs: resv_ready, rs_busy, rt_busy, alu_ready, mem_ready. All others are registered.

## Test plan
- Reset, then alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF, busy_vec[5]=1 → alu_ready=1 in cycle 0; rf_we=1, rf_addr=5, rf_data=0xDEADBEEF in cycle 1; busy_vec[5]=0 from cycle 2; err_unreserved=0.
- Both valid every cycle (ALU addr 3, MEM addr 4, both reserved) → grants ALU, MEM, ALU, MEM; rf_addr sequence 3,4,3,4 with no gaps.
- Reserve 7, then rs_addr=7 → rs_busy=1 until the cycle after the rf_we to 7, then 0. A second resv_addr=7 is refused (resv_ready=0) until the busy bit clears.
- MEM write to register 9 with busy_vec[9]=0 → write committed to 9, err_unreserved=1 and stays 1 across further traffic until reset.
- Assert reset during the cycle after a grant → rf_we=0 immediately; busy_vec=0, `last`=MEM; first post-reset tie grants ALU.
- Reservation to 12 in the same cycle rf_we clears 12 → resv_ready=0 that cycle; accepted the next cycle; busy_vec[12]=1 afterwards.
